jk_cmd_sequencer: RTL
=====================

# jk_cmd_sequencer

Command sequencer that sits directly upstream of the JK flip-flop and drives its J/K inputs. It accepts HOLD/RESET/SET/TOGGLE commands through a valid/ready handshake, buffers them in a small FIFO, and replays each command on J/K for a programmed number of cycles. It also runs a reference model of the flip-flop against the Q/Q_NOT feedback and raises a sticky mismatch flag on any divergence.

## Interface
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- CNT_W, 4: width of the repeat field.

- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  FIFO can accept a command; equals not-full.
- CMD_OP  in  2  {J,K} code: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- CMD_REPEAT  in  CNT_W  command is driven for CMD_REPEAT+1 cycles.
- J  out  1  registered J to the flip-flop.
- K  out  1  registered K to the flip-flop.
- Q_FB  in  1  flip-flop Q.
- Q_NOT_FB  in  1  flip-flop Q_NOT.
- CLR_ERR  in  1  synchronous clear of MISMATCH.
- BUSY  out  1  FSM in ISSUE, or FIFO non-empty.
- EXP_Q  out  1  model's expected Q.
- EXP_VALID  out  1  model is synchronised to the flip-flop.
- MISMATCH  out  1  sticky error flag.

## Operation
**FIFO**
- Push occurs on CMD_VALID & CMD_READY. Each entry holds {op, repeat}.
- CMD_READY is low while the FIFO holds DEPTH entries. A push while not ready is ignored.
- Push and pop in the same cycle is legal. Occupancy is unchanged and the pointers wrap modulo DEPTH.

**FSM: IDLE and ISSUE**
- IDLE, FIFO non-empty: pop the head, load J,K ← op and cnt ← repeat, go to ISSUE.
- IDLE, FIFO empty: J=K=0.
- ISSUE, cnt ≠ 0: cnt ← cnt−1, J/K held.
- ISSUE, cnt = 0, FIFO non-empty: pop the next entry back-to-back, with no bubble cycle.
- ISSUE, cnt = 0, FIFO empty: J=K=0, return to IDLE.
- A repeat of 0 drives the command for exactly one cycle. A repeat of 2^CNT_W−1 drives it for 2^CNT_W cycles; cnt does not wrap.

**Reference model**
- Updated every edge from the current J/K, matching the flip-flop:
  - 00: hold.
  - 01: EXP_Q ← 0.
  - 10: EXP_Q ← 1.
  - 11: EXP_Q ← ~EXP_Q.
- EXP_VALID is set on the edge where a 01 or 10 is applied. It stays set until reset.
- While EXP_VALID = 0, TOGGLE and HOLD leave the model unsynchronised, because the flip-flop has no reset.

**Checker**
- On each edge with EXP_VALID = 1: if Q_FB ≠ EXP_Q or Q_NOT_FB = Q_FB, then MISMATCH ← 1.
- CLR_ERR clears MISMATCH on the next edge. If a new error and CLR_ERR occur on the same edge, the error wins and MISMATCH stays 1.

## Timing
**Reset values**
- Asynchronous, immediate on RST_N low: J=0, K=0, BUSY=0, EXP_Q=0, EXP_VALID=0, MISMATCH=0.
- FIFO empty, so CMD_READY=1. FSM in IDLE, cnt=0.

**Latency**
- Command accepted at edge 0 into an empty, idle block: J/K valid after edge 1.
- The flip-flop and EXP_Q update at edge 2.
- The first comparison against the new value happens at edge 3.
- Earliest MISMATCH assertion is after edge 3.

**Throughput**
- One J/K command per cycle sustained.
- FIFO refill: a push on the same edge as the last-cycle pop keeps the stream gap-free.

**Reset mid-operation**
- FIFO contents and the in-flight command are discarded, and J/K go to 00 immediately.
- EXP_VALID is cleared, so the model must resync via a SET or RESET.

**Handshake**
- CMD_READY depends only on FIFO occupancy, never combinationally on CMD_VALID.
- Data is sampled only on the handshake edge.

## Test plan
- **Reset and basic drive.** After reset, push RESET rep=0 then SET rep=2, with an ideal flip-flop attached.
  - J/K = 01 for 1 cycle, then 10 for 3 cycles, then 00.
  - EXP_Q goes 0 then 1, EXP_VALID=1, MISMATCH=0, BUSY drops after the last cycle.
- **Toggle stream.** SET rep=0, then TOGGLE rep=3.
  - EXP_Q sequence is 1,0,1,0,1 across consecutive edges, with no gap between commands.
  - Q_FB tracks it and MISMATCH stays 0.
- **FIFO full.** Hold the FSM in a SET rep=15 command and push until full.
  - CMD_READY goes 0 after 4 entries, and a 5th push is ignored.
  - Issued order is preserved and the pointers wrap correctly on refill.
- **Injected fault.** After sync to Q=1, force Q_FB=0 for one cycle.
  - MISMATCH=1 on the next edge and stays 1.
  - Pulse CLR_ERR: MISMATCH=0, unless a new fault coincides on the same edge.
- **Unsynchronised checker.** TOGGLE rep=2 straight after reset, with Q_FB=X/0.
  - EXP_VALID=0 and MISMATCH=0 throughout.
- **Reset mid-operation.** Assert RST_N low during a rep=10 command with 2 entries queued.
  - J=K=0 immediately; after release the FIFO is empty, CMD_READY=1 and BUSY=0.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving a JK flip-flop: buffers {op, repeat} commands in a FIFO,
// replays each on J/K for repeat+1 cycles, and checks Q/Q_NOT against a reference model.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [CNT_W-1:0] CMD_REPEAT,
    output logic             J,
    output logic             K,
    input  logic             Q_FB,
    input  logic             Q_NOT_FB,
    input  logic             CLR_ERR,
    output logic             BUSY,
    output logic             EXP_Q,
    output logic             EXP_VALID,
    output logic             MISMATCH
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    logic [CNT_W+1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             j_reg;
    logic             k_reg;
    logic             exp_q_reg;
    logic             exp_valid_reg;
    logic             mismatch_reg;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_rep;
    logic             fb_error;

    assign fifo_empty = (count_reg == '0);
    assign CMD_READY  = (count_reg != (AW+1)'(DEPTH));
    assign push       = CMD_VALID & CMD_READY;
    // Pop whenever the FSM is about to need a new command, so back-to-back commands have no bubble.
    assign pop        = !fifo_empty && ((state_reg == IDLE) || (cnt_reg == '0));
    assign {head_op, head_rep} = mem[rd_ptr_reg];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= {CMD_OP, CMD_REPEAT};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            j_reg     <= 1'b0;
            k_reg     <= 1'b0;
        end else begin
            if ((state_reg == ISSUE) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end else if (pop) begin
                {j_reg, k_reg} <= head_op;
                cnt_reg        <= head_rep;
                state_reg      <= ISSUE;
            end else begin
                {j_reg, k_reg} <= 2'b00;
                state_reg      <= IDLE;
            end
        end
    end

    // Feedback is only meaningful once a SET or RESET has forced the flop to a known value.
    assign fb_error = exp_valid_reg && ((Q_FB != exp_q_reg) || (Q_NOT_FB == Q_FB));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_q_reg     <= 1'b0;
            exp_valid_reg <= 1'b0;
            mismatch_reg  <= 1'b0;
        end else begin
            case ({j_reg, k_reg})
                2'b01: begin
                    exp_q_reg     <= 1'b0;
                    exp_valid_reg <= 1'b1;
                end
                2'b10: begin
                    exp_q_reg     <= 1'b1;
                    exp_valid_reg <= 1'b1;
                end
                2'b11:   exp_q_reg <= ~exp_q_reg;
                default: exp_q_reg <= exp_q_reg;
            endcase
            if (fb_error) begin
                mismatch_reg <= 1'b1;
            end else if (CLR_ERR) begin
                mismatch_reg <= 1'b0;
            end
        end
    end

    assign J         = j_reg;
    assign K         = k_reg;
    assign BUSY      = (state_reg == ISSUE) || !fifo_empty;
    assign EXP_Q     = exp_q_reg;
    assign EXP_VALID = exp_valid_reg;
    assign MISMATCH  = mismatch_reg;

endmodule
